// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline types: opcodes, control enums and stage bundles.
// Used by the decode, control-pipe and branch-resolve logic.
package rv32_pkg;

    typedef enum logic [6:0] {
        OC_R       = 7'b0110011,
        OC_I       = 7'b0010011,
        OC_I_LOAD  = 7'b0000011,
        OC_S       = 7'b0100011,
        OC_B       = 7'b1100011,
        OC_J       = 7'b1101111,
        OC_I_JALR  = 7'b1100111,
        OC_U_LUI   = 7'b0110111,
        OC_U_AUIPC = 7'b0010111
    } opcode_t;

    typedef logic [2:0] funct3_t;

    localparam funct3_t F3_BEQ  = 3'b000;
    localparam funct3_t F3_BNE  = 3'b001;
    localparam funct3_t F3_BLT  = 3'b100;
    localparam funct3_t F3_BGE  = 3'b101;
    localparam funct3_t F3_BLTU = 3'b110;
    localparam funct3_t F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_BSEL
    } ALUSel_t;

    typedef enum logic [1:0] {
        WB_MEM = 2'd0,
        WB_ALU = 2'd1,
        WB_PC4 = 2'd2
    } WBSel_t;

    typedef enum logic {
        PC_PC4 = 1'b0,
        PC_ALU = 1'b1
    } PCSel_t;

    typedef struct packed {
        logic       valid;
        logic       ASel;
        logic       BSel;
        logic       BrUn;
        ALUSel_t    ALUSel;
        logic       MemRW;
        logic       RegWEn;
        WBSel_t     WBSel;
        logic [4:0] rd;
        opcode_t    opcode;
        funct3_t    funct3;
    } ctrl_word_t;

    typedef struct packed {
        logic       valid;
        logic       MemRW;
        logic       RegWEn;
        WBSel_t     WBSel;
        logic [4:0] rd;
    } mem_ctrl_t;

    typedef struct packed {
        logic       valid;
        logic       RegWEn;
        WBSel_t     WBSel;
        logic [4:0] rd;
    } wb_ctrl_t;

    localparam ctrl_word_t CTRL_BUBBLE = '{
        valid: 1'b0, ASel: 1'b0, BSel: 1'b0, BrUn: 1'b0,
        ALUSel: ALU_ADD, MemRW: 1'b0, RegWEn: 1'b0,
        WBSel: WB_ALU, rd: 5'd0, opcode: OC_R, funct3: 3'b000
    };

    localparam mem_ctrl_t MEM_BUBBLE = '{
        valid: 1'b0, MemRW: 1'b0, RegWEn: 1'b0,
        WBSel: WB_ALU, rd: 5'd0
    };

    localparam wb_ctrl_t WB_BUBBLE = '{
        valid: 1'b0, RegWEn: 1'b0, WBSel: WB_ALU, rd: 5'd0
    };

endpackage

// File: rtl/branch_resolve.sv
// Branch/jump resolution for the EX instruction.
// In: opcode, funct3, valid, BrEq, BrLT. Out: taken.
module branch_resolve
    import rv32_pkg::*;
(
    input  opcode_t opcode,
    input  funct3_t funct3,
    input  logic    valid,
    input  logic    BrEq,
    input  logic    BrLT,
    output logic    taken
);

    logic w_br;

    always_comb begin
        w_br = 1'b0;
        unique case (funct3)
            F3_BEQ:  w_br = BrEq;
            F3_BNE:  w_br = ~BrEq;
            F3_BLT:  w_br = BrLT;
            F3_BGE:  w_br = ~BrLT;
            F3_BLTU: w_br = BrLT;
            F3_BGEU: w_br = ~BrLT;
            default: w_br = 1'b0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        if (valid) begin
            if (opcode == OC_J || opcode == OC_I_JALR) begin
                taken = 1'b1;
            end else if (opcode == OC_B) begin
                taken = w_br;
            end
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Control-word transport through ID/EX, EX/MEM, MEM/WB with EX redirect.
// In: id_* control, stall, ex_Br*. Out: ex_/mem_/wb_* words, PCSel, flush, taken_cnt.
module ctrl_pipe
    import rv32_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  opcode_t          id_opcode,
    input  funct3_t          id_funct3,
    input  logic [4:0]       id_rd,
    input  logic             id_ASel,
    input  logic             id_BSel,
    input  logic             id_BrUn,
    input  logic             id_MemRW,
    input  logic             id_RegWEn,
    input  ALUSel_t          id_ALUSel,
    input  WBSel_t           id_WBSel,
    input  logic             stall,
    input  logic             ex_BrEq,
    input  logic             ex_BrLT,
    output logic             ex_valid,
    output logic             ex_ASel,
    output logic             ex_BSel,
    output logic             ex_BrUn,
    output ALUSel_t          ex_ALUSel,
    output logic             ex_MemRW,
    output logic             ex_RegWEn,
    output WBSel_t           ex_WBSel,
    output logic [4:0]       ex_rd,
    output logic             mem_valid,
    output logic             mem_MemRW,
    output logic             mem_RegWEn,
    output WBSel_t           mem_WBSel,
    output logic [4:0]       mem_rd,
    output logic             wb_valid,
    output logic             wb_RegWEn,
    output WBSel_t           wb_WBSel,
    output logic [4:0]       wb_rd,
    output PCSel_t           PCSel,
    output logic             flush,
    output logic [CNT_W-1:0] taken_cnt
);

    ctrl_word_t       w_id;
    ctrl_word_t       r_ex;
    mem_ctrl_t        r_mem;
    wb_ctrl_t         r_wb;
    logic             w_taken;
    logic [CNT_W-1:0] r_cnt;

    // Writes to x0 and non-instructions must never reach the register file
    always_comb begin
        w_id        = CTRL_BUBBLE;
        w_id.valid  = id_valid;
        w_id.ASel   = id_ASel;
        w_id.BSel   = id_BSel;
        w_id.BrUn   = id_BrUn;
        w_id.ALUSel = id_ALUSel;
        w_id.MemRW  = id_MemRW & id_valid;
        w_id.RegWEn = id_RegWEn & id_valid & (id_rd != 5'd0);
        w_id.WBSel  = id_WBSel;
        w_id.rd     = id_rd;
        w_id.opcode = id_opcode;
        w_id.funct3 = id_funct3;
    end

    branch_resolve u_br (
        .opcode (r_ex.opcode),
        .funct3 (r_ex.funct3),
        .valid  (r_ex.valid),
        .BrEq   (ex_BrEq),
        .BrLT   (ex_BrLT),
        .taken  (w_taken)
    );

    // Only ID/EX reacts to flush/stall; later stages always drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex  <= CTRL_BUBBLE;
            r_mem <= MEM_BUBBLE;
            r_wb  <= WB_BUBBLE;
            r_cnt <= '0;
        end else begin
            if (w_taken || stall) begin
                r_ex <= CTRL_BUBBLE;
            end else begin
                r_ex <= w_id;
            end
            r_mem.valid  <= r_ex.valid;
            r_mem.MemRW  <= r_ex.MemRW;
            r_mem.RegWEn <= r_ex.RegWEn;
            r_mem.WBSel  <= r_ex.WBSel;
            r_mem.rd     <= r_ex.rd;
            r_wb.valid   <= r_mem.valid;
            r_wb.RegWEn  <= r_mem.RegWEn;
            r_wb.WBSel   <= r_mem.WBSel;
            r_wb.rd      <= r_mem.rd;
            if (w_taken) begin
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign ex_valid   = r_ex.valid;
    assign ex_ASel    = r_ex.ASel;
    assign ex_BSel    = r_ex.BSel;
    assign ex_BrUn    = r_ex.BrUn;
    assign ex_ALUSel  = r_ex.ALUSel;
    assign ex_MemRW   = r_ex.MemRW;
    assign ex_RegWEn  = r_ex.RegWEn;
    assign ex_WBSel   = r_ex.WBSel;
    assign ex_rd      = r_ex.rd;
    assign mem_valid  = r_mem.valid;
    assign mem_MemRW  = r_mem.MemRW;
    assign mem_RegWEn = r_mem.RegWEn;
    assign mem_WBSel  = r_mem.WBSel;
    assign mem_rd     = r_mem.rd;
    assign wb_valid   = r_wb.valid;
    assign wb_RegWEn  = r_wb.RegWEn;
    assign wb_WBSel   = r_wb.WBSel;
    assign wb_rd      = r_wb.rd;
    assign PCSel      = w_taken ? PC_ALU : PC_PC4;
    assign flush      = w_taken;
    assign taken_cnt  = r_cnt;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: directed plan items plus random traffic.
// Retirements are checked by a monitor against a queue filled at EX entry.
module tb_ctrl_pipe;
    import rv32_pkg::*;

    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          id_valid;
    opcode_t       id_opcode;
    funct3_t       id_funct3;
    logic [4:0]    id_rd;
    logic          id_ASel, id_BSel, id_BrUn, id_MemRW, id_RegWEn;
    ALUSel_t       id_ALUSel;
    WBSel_t        id_WBSel;
    logic          stall, ex_BrEq, ex_BrLT;
    logic          ex_valid, ex_ASel, ex_BSel, ex_BrUn;
    ALUSel_t       ex_ALUSel;
    logic          ex_MemRW, ex_RegWEn;
    WBSel_t        ex_WBSel;
    logic [4:0]    ex_rd;
    logic          mem_valid, mem_MemRW, mem_RegWEn;
    WBSel_t        mem_WBSel;
    logic [4:0]    mem_rd;
    logic          wb_valid, wb_RegWEn;
    WBSel_t        wb_WBSel;
    logic [4:0]    wb_rd;
    PCSel_t        PCSel;
    logic          flush;
    logic [CW-1:0] taken_cnt;

    ctrl_pipe #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_opcode(id_opcode),
        .id_funct3(id_funct3), .id_rd(id_rd),
        .id_ASel(id_ASel), .id_BSel(id_BSel), .id_BrUn(id_BrUn),
        .id_MemRW(id_MemRW), .id_RegWEn(id_RegWEn),
        .id_ALUSel(id_ALUSel), .id_WBSel(id_WBSel),
        .stall(stall), .ex_BrEq(ex_BrEq), .ex_BrLT(ex_BrLT),
        .ex_valid(ex_valid), .ex_ASel(ex_ASel), .ex_BSel(ex_BSel),
        .ex_BrUn(ex_BrUn), .ex_ALUSel(ex_ALUSel),
        .ex_MemRW(ex_MemRW), .ex_RegWEn(ex_RegWEn),
        .ex_WBSel(ex_WBSel), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_MemRW(mem_MemRW),
        .mem_RegWEn(mem_RegWEn), .mem_WBSel(mem_WBSel),
        .mem_rd(mem_rd),
        .wb_valid(wb_valid), .wb_RegWEn(wb_RegWEn),
        .wb_WBSel(wb_WBSel), .wb_rd(wb_rd),
        .PCSel(PCSel), .flush(flush), .taken_cnt(taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       RegWEn;
        WBSel_t     WBSel;
        logic [4:0] rd;
        int         due;
    } ret_t;

    ret_t          exp_q[$];
    ctrl_word_t    m_ex;
    logic [CW-1:0] m_cnt;
    int            cyc;
    int            n_chk;
    int            n_fail;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Redirect rule: jumps always; branches compare on EQ (f3[2]=0) or
    // LT (f3[2]=1), with f3[0] inverting; f3 01x is not a branch.
    function automatic bit ref_taken(ctrl_word_t c, bit eq, bit lt);
        if (!c.valid) return 1'b0;
        if (c.opcode == OC_J || c.opcode == OC_I_JALR) return 1'b1;
        if (c.opcode != OC_B) return 1'b0;
        if (c.funct3[2:1] == 2'b01) return 1'b0;
        return (c.funct3[2] ? lt : eq) ^ c.funct3[0];
    endfunction

    function automatic ctrl_word_t mk(bit v, opcode_t op, funct3_t f3,
                                      logic [4:0] rd, bit we, bit mw,
                                      WBSel_t wbs);
        ctrl_word_t w;
        w        = CTRL_BUBBLE;
        w.valid  = v;
        w.opcode = op;
        w.funct3 = f3;
        w.rd     = rd;
        w.RegWEn = we;
        w.MemRW  = mw;
        w.WBSel  = wbs;
        return w;
    endfunction

    function automatic ctrl_word_t rnd_word();
        ctrl_word_t w;
        opcode_t ops[7];
        ops = '{OC_R, OC_I, OC_I_LOAD, OC_S, OC_B, OC_J, OC_I_JALR};
        w        = CTRL_BUBBLE;
        w.valid  = ($urandom_range(0, 99) < 85);
        w.opcode = ops[$urandom_range(0, 6)];
        w.funct3 = 3'($urandom_range(0, 7));
        w.rd     = ($urandom_range(0, 4) == 0) ? 5'd0
                                               : 5'($urandom_range(1, 31));
        w.RegWEn = 1'($urandom_range(0, 1));
        w.MemRW  = 1'($urandom_range(0, 1));
        w.ASel   = 1'($urandom_range(0, 1));
        w.BSel   = 1'($urandom_range(0, 1));
        w.BrUn   = 1'($urandom_range(0, 1));
        w.ALUSel = ALUSel_t'(4'($urandom_range(0, 10)));
        w.WBSel  = WBSel_t'(2'($urandom_range(0, 2)));
        return w;
    endfunction

    task automatic step(input ctrl_word_t d, input bit st,
                        input bit eq, input bit lt);
        bit         tk;
        ctrl_word_t q;
        ret_t       r;
        @(negedge clk);
        id_valid  = d.valid;
        id_opcode = d.opcode;
        id_funct3 = d.funct3;
        id_rd     = d.rd;
        id_ASel   = d.ASel;
        id_BSel   = d.BSel;
        id_BrUn   = d.BrUn;
        id_MemRW  = d.MemRW;
        id_RegWEn = d.RegWEn;
        id_ALUSel = d.ALUSel;
        id_WBSel  = d.WBSel;
        stall     = st;
        ex_BrEq   = eq;
        ex_BrLT   = lt;
        #1;
        tk = ref_taken(m_ex, eq, lt);
        chk("pcsel", 32'(PCSel), tk ? 32'(PC_ALU) : 32'(PC_PC4));
        chk("flush", 32'(flush), 32'(tk));
        chk("taken_cnt", 32'(taken_cnt), 32'(m_cnt));
        chk("ex_word",
            32'({ex_valid, ex_ASel, ex_BSel, ex_BrUn, ex_ALUSel,
                 ex_MemRW, ex_RegWEn, ex_WBSel, ex_rd}),
            32'({m_ex.valid, m_ex.ASel, m_ex.BSel, m_ex.BrUn,
                 m_ex.ALUSel, m_ex.MemRW, m_ex.RegWEn,
                 m_ex.WBSel, m_ex.rd}));
        @(posedge clk);
        if (tk) m_cnt = m_cnt + 1'b1;
        q        = d;
        q.RegWEn = d.RegWEn && d.valid && (d.rd != 5'd0);
        q.MemRW  = d.MemRW && d.valid;
        m_ex     = (tk || st) ? CTRL_BUBBLE : q;
        cyc++;
        if (m_ex.valid) begin
            r.RegWEn = m_ex.RegWEn;
            r.WBSel  = m_ex.WBSel;
            r.rd     = m_ex.rd;
            r.due    = cyc + 2;
            exp_q.push_back(r);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ex_valid"}, 32'(ex_valid), 0);
        chk({tag, "_ex_word"},
            32'({ex_RegWEn, ex_MemRW, ex_ALUSel, ex_WBSel, ex_rd}),
            32'({1'b0, 1'b0, ALU_ADD, WB_ALU, 5'd0}));
        chk({tag, "_mem"},
            32'({mem_valid, mem_MemRW, mem_RegWEn, mem_WBSel, mem_rd}),
            32'({1'b0, 1'b0, 1'b0, WB_ALU, 5'd0}));
        chk({tag, "_wb"},
            32'({wb_valid, wb_RegWEn, wb_WBSel, wb_rd}),
            32'({1'b0, 1'b0, WB_ALU, 5'd0}));
        chk({tag, "_pcsel"}, 32'(PCSel), 32'(PC_PC4));
        chk({tag, "_flush"}, 32'(flush), 0);
        chk({tag, "_cnt"}, 32'(taken_cnt), 0);
        exp_q.delete();
        m_ex  = CTRL_BUBBLE;
        m_cnt = '0;
    endtask

    // Retirement monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    chk("wb_spurious", 32'(wb_valid), 0);
                end else begin
                    ret_t e;
                    e = exp_q.pop_front();
                    chk("wb_word", 32'({wb_RegWEn, wb_WBSel, wb_rd}),
                        32'({e.RegWEn, e.WBSel, e.rd}));
                    chk("wb_latency", 32'(cyc), 32'(e.due));
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                void'(exp_q.pop_front());
                chk("wb_missing", 32'(wb_valid), 1);
            end
        end
    end

    ctrl_word_t NOP;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        NOP    = CTRL_BUBBLE;
        rst_n  = 1'b0;
        id_valid = 0; id_opcode = OC_R; id_funct3 = 3'b000;
        id_rd = 0; id_ASel = 0; id_BSel = 0; id_BrUn = 0;
        id_MemRW = 0; id_RegWEn = 0; id_ALUSel = ALU_ADD;
        id_WBSel = WB_ALU; stall = 0; ex_BrEq = 0; ex_BrLT = 0;
        #12;
        check_reset_state("rst");
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Straight line ADD x5
        step(mk(1, OC_R, 3'b000, 5'd5, 1, 0, WB_ALU), 0, 0, 0);
        repeat (3) step(NOP, 0, 0, 0);
        // BEQ taken, the younger ADD is squashed
        step(mk(1, OC_B, F3_BEQ, 5'd0, 0, 0, WB_ALU), 0, 0, 0);
        step(mk(1, OC_R, 3'b000, 5'd7, 1, 0, WB_ALU), 0, 1, 0);
        step(NOP, 0, 0, 0);
        // BGEU with LT not taken; BLT with LT taken
        step(mk(1, OC_B, F3_BGEU, 5'd0, 0, 0, WB_ALU), 0, 0, 1);
        step(mk(1, OC_B, F3_BLT, 5'd0, 0, 0, WB_ALU), 0, 0, 1);
        step(mk(1, OC_R, 3'b000, 5'd9, 1, 0, WB_ALU), 0, 0, 1);
        // Back-to-back branches, first not taken
        step(mk(1, OC_B, F3_BNE, 5'd0, 0, 0, WB_ALU), 0, 1, 0);
        step(mk(1, OC_B, F3_BEQ, 5'd0, 0, 0, WB_ALU), 0, 1, 0);
        step(NOP, 0, 1, 0);
        // Stall for two cycles with an ADDI in ID
        step(mk(1, OC_R, 3'b000, 5'd3, 1, 0, WB_ALU), 0, 0, 0);
        step(mk(1, OC_I, 3'b000, 5'd4, 1, 0, WB_ALU), 1, 0, 0);
        step(mk(1, OC_I, 3'b000, 5'd4, 1, 0, WB_ALU), 1, 0, 0);
        step(mk(1, OC_I, 3'b000, 5'd4, 1, 0, WB_ALU), 0, 0, 0);
        // Taken JAL with a simultaneous stall
        step(mk(1, OC_J, 3'b000, 5'd1, 1, 0, WB_PC4), 0, 0, 0);
        step(mk(1, OC_R, 3'b000, 5'd6, 1, 0, WB_ALU), 1, 0, 0);
        // Write to x0 retires with RegWEn low
        step(mk(1, OC_R, 3'b000, 5'd0, 1, 0, WB_ALU), 0, 0, 0);
        repeat (3) step(NOP, 0, 0, 0);

        // Reset while a SW sits in EX/MEM
        step(mk(1, OC_S, 3'b010, 5'd0, 0, 1, WB_MEM), 0, 0, 0);
        step(NOP, 0, 0, 0);
        #1 chk("sw_in_mem", 32'(mem_MemRW), 1);
        #1 rst_n = 1'b0;
        #1 check_reset_state("midrst");
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // 16 redirects wrap the 4-bit counter
        repeat (32) step(mk(1, OC_J, 3'b000, 5'd1, 1, 0, WB_PC4), 0, 0, 0);
        #1 chk("cnt_wrap", 32'(taken_cnt), 0);

        repeat (400) begin
            step(rnd_word(), ($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        repeat (4) step(NOP, 0, 0, 0);
        chk("drain", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
